// File: rtl/round_judge.sv
// ============================================================================
// Module   : round_judge
// Brief    : Arbitrates one answer round among NUM_PLAYERS players.
// Revision : 1.0
// ============================================================================
`default_nettype none

module round_judge #(
    parameter int NUM_PLAYERS    = 2,
    parameter int TIMER_W        = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ROUND_START,
    input  logic [NUM_PLAYERS-1:0] CORRECT,
    input  logic [NUM_PLAYERS-1:0] WRONG,
    output logic                   BUSY,
    output logic [NUM_PLAYERS-1:0] WINNER,
    output logic                   DRAW,
    output logic                   TIMEOUT,
    output logic                   RESULT_VALID,
    output logic [TIMER_W-1:0]     ELAPSED
);

    localparam bit               C_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_W-1:0] C_TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OPEN = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_PLAYERS-1:0]   lock_q, lock_d;
    logic [TIMER_W-1:0]       cnt_q, cnt_d;
    logic [NUM_PLAYERS-1:0]   winner_q, winner_d;
    logic                     draw_q, draw_d;
    logic                     timeout_q, timeout_d;
    logic                     valid_q, valid_d;
    logic [TIMER_W-1:0]       elapsed_q, elapsed_d;

    logic [NUM_PLAYERS-1:0]   w_eligible;
    logic                     w_multi;

    assign w_eligible = CORRECT & ~lock_q;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi    = |(w_eligible & (w_eligible - NUM_PLAYERS'(1)));

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        winner_d  = winner_q;
        draw_d    = draw_q;
        timeout_d = timeout_q;
        elapsed_d = elapsed_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ROUND_START) begin
                    state_d   = S_OPEN;
                    lock_d    = '0;
                    cnt_d     = '0;
                    winner_d  = '0;
                    draw_d    = 1'b0;
                    timeout_d = 1'b0;
                    elapsed_d = '0;
                end
            end
            S_OPEN: begin
                if (w_eligible != '0) begin
                    state_d   = S_IDLE;
                    winner_d  = w_eligible;
                    draw_d    = w_multi;
                    timeout_d = 1'b0;
                    elapsed_d = cnt_q;
                    valid_d   = 1'b1;
                end else if (&(lock_q | WRONG)) begin
                    state_d   = S_IDLE;
                    winner_d  = '0;
                    draw_d    = 1'b0;
                    timeout_d = 1'b0;
                    elapsed_d = cnt_q;
                    valid_d   = 1'b1;
                end else if (C_TO_EN && (cnt_q == C_TO_LAST)) begin
                    state_d   = S_IDLE;
                    winner_d  = '0;
                    draw_d    = 1'b0;
                    timeout_d = 1'b1;
                    elapsed_d = cnt_q;
                    valid_d   = 1'b1;
                end else begin
                    // A same-cycle correct pulse overrides wrong, so it never locks.
                    lock_d = lock_q | (WRONG & ~CORRECT);
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + TIMER_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            lock_q    <= '0;
            cnt_q     <= '0;
            winner_q  <= '0;
            draw_q    <= 1'b0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            elapsed_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            winner_q  <= winner_d;
            draw_q    <= draw_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
            elapsed_q <= elapsed_d;
        end
    end

    assign BUSY         = (state_q == S_OPEN);
    assign WINNER       = winner_q;
    assign DRAW         = draw_q;
    assign TIMEOUT      = timeout_q;
    assign RESULT_VALID = valid_q;
    assign ELAPSED      = elapsed_q;

endmodule

`default_nettype wire

// File: tb/tb_round_judge.sv
// ============================================================================
// Module   : tb_round_judge
// Brief    : Three round_judge configurations against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_round_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs  [3];
    logic [3:0] cor [3];
    logic [3:0] wr  [3];

    always #5 clk = ~clk;

    logic        busy0, busy1, busy2, drw0, drw1, drw2, to0, to1, to2, val0, val1, val2;
    logic [1:0]  win0, win1;
    logic [3:0]  win2;
    logic [15:0] el0, el1, el2;

    round_judge #(.NUM_PLAYERS(2), .TIMER_W(16), .TIMEOUT_CYCLES(1000)) u_d0 (
        .CLK(clk), .RST(rst), .ROUND_START(rs[0]), .CORRECT(cor[0][1:0]), .WRONG(wr[0][1:0]),
        .BUSY(busy0), .WINNER(win0), .DRAW(drw0), .TIMEOUT(to0), .RESULT_VALID(val0), .ELAPSED(el0));
    round_judge #(.NUM_PLAYERS(2), .TIMER_W(16), .TIMEOUT_CYCLES(10)) u_d1 (
        .CLK(clk), .RST(rst), .ROUND_START(rs[1]), .CORRECT(cor[1][1:0]), .WRONG(wr[1][1:0]),
        .BUSY(busy1), .WINNER(win1), .DRAW(drw1), .TIMEOUT(to1), .RESULT_VALID(val1), .ELAPSED(el1));
    round_judge #(.NUM_PLAYERS(4), .TIMER_W(16), .TIMEOUT_CYCLES(20)) u_d2 (
        .CLK(clk), .RST(rst), .ROUND_START(rs[2]), .CORRECT(cor[2]), .WRONG(wr[2]),
        .BUSY(busy2), .WINNER(win2), .DRAW(drw2), .TIMEOUT(to2), .RESULT_VALID(val2), .ELAPSED(el2));

    logic [24:0] dut_v [3];
    always_comb begin
        dut_v[0] = {busy0, 2'b00, win0, drw0, to0, val0, el0};
        dut_v[1] = {busy1, 2'b00, win1, drw1, to1, val1, el1};
        dut_v[2] = {busy2, win2, drw2, to2, val2, el2};
    end

    int NP  [3] = '{2, 2, 4};
    int TOC [3] = '{1000, 10, 20};

    bit       m_open [3];
    int       m_cnt  [3];
    bit [3:0] m_lock [3];
    bit [3:0] m_win  [3];
    bit       m_draw [3];
    bit       m_to   [3];
    bit       m_val  [3];
    int       m_el   [3];

    int vectors = 0;
    int miss    = 0;
    bit armed   = 1'b0;

    task automatic finish_round(input int k, input bit [3:0] w, input bit d, input bit t);
        m_win[k]  = w;
        m_draw[k] = d;
        m_to[k]   = t;
        m_el[k]   = m_cnt[k];
        m_val[k]  = 1'b1;
        m_open[k] = 1'b0;
    endtask

    task automatic model_step(input int k);
        bit [3:0] full, elig;
        int       nel;
        full = 4'((1 << NP[k]) - 1);
        m_val[k] = 1'b0;
        if (rst) begin
            m_open[k] = 0; m_cnt[k] = 0; m_lock[k] = 0;
            m_win[k] = 0; m_draw[k] = 0; m_to[k] = 0; m_el[k] = 0;
        end else if (!m_open[k]) begin
            if (rs[k]) begin
                m_open[k] = 1; m_cnt[k] = 0; m_lock[k] = 0;
                m_win[k] = 0; m_draw[k] = 0; m_to[k] = 0; m_el[k] = 0;
            end
        end else begin
            elig = cor[k] & ~m_lock[k] & full;
            nel  = 0;
            for (int i = 0; i < 4; i++) if (elig[i]) nel++;
            if (nel > 0)
                finish_round(k, elig, nel > 1, 1'b0);
            else if (((m_lock[k] | wr[k]) & full) == full)
                finish_round(k, 4'd0, 1'b0, 1'b0);
            else if (TOC[k] != 0 && m_cnt[k] == TOC[k] - 1)
                finish_round(k, 4'd0, 1'b0, 1'b1);
            else begin
                m_lock[k] = m_lock[k] | (wr[k] & ~cor[k] & full);
                if (m_cnt[k] < 65535) m_cnt[k]++;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                logic [24:0] exp_v;
                exp_v = {m_open[k], m_win[k], m_draw[k], m_to[k], m_val[k], 16'(m_el[k])};
                vectors++;
                if (dut_v[k] !== exp_v) begin
                    miss++;
                    $display("FAIL model_d%0d t=%0t got busy/win/draw/to/val/el=%h want %h",
                             k, $time, dut_v[k], exp_v);
                end
            end
        end
    end

    task automatic chk(input string name, input int k, input bit b, input bit [3:0] w,
                       input bit d, input bit t, input bit v, input int e);
        logic [24:0] exp_v;
        exp_v = {b, w, d, t, v, 16'(e)};
        vectors++;
        if (dut_v[k] !== exp_v) begin
            miss++;
            $display("FAIL %s got busy/win/draw/to/val/el=%h want %h", name, dut_v[k], exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input int k);
        rs[k] = 1'b1;
        tick();
        rs[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rs[k] = 1'b0; cor[k] = 4'd0; wr[k] = 4'd0;
        end
        repeat (2) tick();
        rst = 1'b0;
        armed = 1'b1;
        chk("reset_d0", 0, 0, 4'd0, 0, 0, 0, 0);
        chk("reset_d2", 2, 0, 4'd0, 0, 0, 0, 0);

        // Single winner at cycle 5, then held
        start(0); repeat (5) tick();
        cor[0] = 4'b0001; tick(); cor[0] = 4'd0;
        chk("first_win", 0, 0, 4'b0001, 0, 0, 1, 5);
        tick();
        chk("win_held", 0, 0, 4'b0001, 0, 0, 0, 5);

        // Same-cycle tie
        start(0); repeat (3) tick();
        cor[0] = 4'b0011; tick(); cor[0] = 4'd0;
        chk("tie", 0, 0, 4'b0011, 1, 0, 1, 3);

        // Lockout
        start(0); repeat (2) tick();
        wr[0] = 4'b0010; tick(); wr[0] = 4'd0;
        tick();
        cor[0] = 4'b0010; tick(); cor[0] = 4'd0;
        chk("locked_ignored", 0, 1, 4'd0, 0, 0, 0, 0);
        tick();
        cor[0] = 4'b0001; tick(); cor[0] = 4'd0;
        chk("lockout_win", 0, 0, 4'b0001, 0, 0, 1, 6);

        // All wrong
        start(0); tick();
        wr[0] = 4'b0001; tick(); wr[0] = 4'd0;
        repeat (2) tick();
        wr[0] = 4'b0010; tick(); wr[0] = 4'd0;
        chk("all_wrong", 0, 0, 4'd0, 0, 0, 1, 4);

        // Timeout and last-cycle correct
        start(1); repeat (9) tick();
        chk("before_timeout", 1, 1, 4'd0, 0, 0, 0, 0);
        tick();
        chk("timeout", 1, 0, 4'd0, 0, 1, 1, 9);
        start(1); repeat (9) tick();
        cor[1] = 4'b0010; tick(); cor[1] = 4'd0;
        chk("late_correct", 1, 0, 4'b0010, 0, 0, 1, 9);

        // Mid-round reset on the four-player judge
        start(2); repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_reset", 2, 0, 4'd0, 0, 0, 0, 0);

        // Start pulse during OPEN clears neither counter nor lock
        start(2); tick();
        wr[2] = 4'b0001; tick(); wr[2] = 4'd0;
        rs[2] = 1'b1; tick(); rs[2] = 1'b0;
        repeat (2) tick();
        cor[2] = 4'b0011; tick(); cor[2] = 4'd0;
        chk("start_ignored", 2, 0, 4'b0010, 0, 0, 1, 5);
        rs[2] = 1'b1; tick(); rs[2] = 1'b0;
        chk("back_to_back", 2, 1, 4'd0, 0, 0, 0, 0);

        for (int n = 0; n < 6000; n++) begin
            rst = ($urandom_range(299) == 0);
            for (int k = 0; k < 3; k++) begin
                rs[k] = ($urandom_range(3) == 0);
                for (int i = 0; i < 4; i++) begin
                    cor[k][i] = ($urandom_range(11) == 0);
                    wr[k][i]  = ($urandom_range(7) == 0);
                end
            end
            tick();
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rs[k] = 1'b0; cor[k] = 4'd0; wr[k] = 4'd0;
        end
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/round_judge.md
Name: round_judge

Overview:
- Parametrised successor to the two-player win/lose judge for the factorization game.
- Arbitrates one answer round among NUM_PLAYERS players. A round is opened by a start strobe. Per-player correct/wrong answer pulses are sampled each cycle.
- Reports the first player(s) to answer correctly, or a timeout / all-wrong outcome, to downstream HP management.
- New relative to the two-player judge: per-player wrong-answer lockout, round timeout, response-time capture, and a one-cycle result-valid strobe.

Parameters:
- NUM_PLAYERS, 2, number of competing players (at least 2).
- TIMER_W, 16, width of the round cycle counter.
- TIMEOUT_CYCLES, 1000, round length in clock cycles; 0 disables the timeout. Must fit in TIMER_W bits.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- ROUND_START  input  1  opens a round; accepted only in IDLE.
- CORRECT  input  NUM_PLAYERS  bit i pulses when player i's answer checks correct.
- WRONG  input  NUM_PLAYERS  bit i pulses when player i's answer checks wrong.
- BUSY  output  1  high while the round is OPEN.
- WINNER  output  NUM_PLAYERS  mask of winning player(s); held until next round start.
- DRAW  output  1  more than one WINNER bit set; held.
- TIMEOUT  output  1  round ended by timeout; held.
- RESULT_VALID  output  1  one-cycle strobe when WINNER/DRAW/TIMEOUT/ELAPSED update.
- ELAPSED  output  TIMER_W  OPEN-cycle index at decision (response time); held.

Behaviour:
- Reset (RST=1 at a clock edge): state=IDLE, lock mask=0, counter=0. All outputs go to 0 after that edge.
- Reset mid-round: the round is aborted and no RESULT_VALID is issued.
- States: IDLE, OPEN. All outputs are registered.
- IDLE:
  - BUSY=0.
  - ROUND_START=1 -> OPEN. Same edge: lock=0, counter=0, WINNER=0, DRAW=0, TIMEOUT=0, ELAPSED=0.
  - CORRECT/WRONG are ignored in IDLE.
- OPEN:
  - BUSY=1. ROUND_START is ignored.
  - Each cycle: eligible = CORRECT & ~lock, using the lock value registered before this cycle.
- OPEN decision priority, evaluated each cycle:
  1. eligible != 0:
     - WINNER <= eligible.
     - DRAW <= (popcount(eligible) > 1).
     - TIMEOUT <= 0; ELAPSED <= counter; -> IDLE.
  2. Else, if (lock | WRONG) is all ones:
     - WINNER <= 0, DRAW <= 0, TIMEOUT <= 0, ELAPSED <= counter; -> IDLE.
  3. Else, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1:
     - WINNER <= 0, DRAW <= 0, TIMEOUT <= 1, ELAPSED <= counter; -> IDLE.
  4. Else:
     - lock <= lock | (WRONG & ~CORRECT).
     - counter <= counter+1, saturating at all-ones.
     - Stay in OPEN.
- Simultaneous events:
  - CORRECT and WRONG on the same bit in the same cycle counts as CORRECT.
  - A locked player's CORRECT is ignored.
  - A CORRECT in the final timeout cycle wins over the timeout.
- RESULT_VALID:
  - Goes high on every OPEN->IDLE edge caused by a decision, for exactly one cycle.
  - Latency: CORRECT sampled at edge k -> RESULT_VALID and WINNER visible in the cycle following edge k.
- Back-to-back rounds: ROUND_START may be high in the RESULT_VALID cycle. It opens a new round, clearing held outputs at the next edge.
- Two-player mapping for HP management:
  - WINNER=01 -> self wins.
  - WINNER=10 -> enemy wins.
  - WINNER=11 -> draw.
  - WINNER=00 -> no result.

Test Plan:
- NUM_PLAYERS=2, TIMEOUT_CYCLES=1000: ROUND_START, then CORRECT=01 at OPEN cycle 5 -> next cycle RESULT_VALID=1 (one cycle), WINNER=01, DRAW=0, TIMEOUT=0, ELAPSED=5, BUSY=0.
- Same-cycle tie: CORRECT=11 at OPEN cycle 3 -> WINNER=11, DRAW=1, ELAPSED=3.
- Lockout: WRONG=10 at cycle 2, then CORRECT=10 at cycle 4 (ignored), then CORRECT=01 at cycle 6 -> WINNER=01, ELAPSED=6.
- All wrong: WRONG=01 at cycle 1, WRONG=10 at cycle 4 -> RESULT_VALID with WINNER=00, TIMEOUT=0, ELAPSED=4.
- Timeout, TIMEOUT_CYCLES=10, no answers -> RESULT_VALID after OPEN cycle 9, TIMEOUT=1, WINNER=00, ELAPSED=9. Repeat with CORRECT=10 at cycle 9 -> WINNER=10, TIMEOUT=0.
- Reset and restart, NUM_PLAYERS=4:
  - RST at OPEN cycle 3 -> BUSY=0 and all outputs 0 after that edge, no RESULT_VALID.
  - ROUND_START pulses during OPEN are ignored: counter not cleared, lock not cleared.
  - ROUND_START high in the RESULT_VALID cycle -> BUSY=1 and WINNER cleared next cycle.
